// File: rtl/acc_muldiv_unit.sv
// acc_muldiv_unit: iterative unsigned shift-add multiplier / restoring divider feeding the accumulator.
// Define ACC_MULDIV_DIV_EN to compile in the divider and DivZero; otherwise every operation multiplies.
module acc_muldiv_unit #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Op,
  input  logic [W-1:0] AccIn,
  input  logic [W-1:0] RegIn,
  output logic         Busy,
  output logic         Done,
  output logic         write_en_acc,
  output logic [W-1:0] DataOut,
  output logic [W-1:0] HiOut,
  output logic         DivZero
);
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0] opnd;
  logic [2*W-1:0] prod, prod_nx, mul_nx;
  logic [W:0] sum;
  logic op_q, op_in, dz, dz_q, last;
  // Multiply: upper half accumulates the multiplicand, lower half holds the shifting multiplier.
  assign sum = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, opnd} : '0);
  assign mul_nx = {sum, prod[W-1:1]};
`ifdef ACC_MULDIV_DIV_EN
  logic [W:0] trial;
  logic [W-1:0] rem;
  logic ge;
  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  assign trial = {prod[2*W-1:W], prod[W-1]};
  assign ge = trial >= {1'b0, opnd};
  assign rem = ge ? trial[W-1:0] - opnd : trial[W-1:0];
  assign op_in = Op;
  assign dz = op_q && opnd == '0;
  assign prod_nx = op_q ? {rem, prod[W-2:0], ge} : mul_nx;
`else
  logic unused_op;
  assign unused_op = Op | op_q;
  assign op_in = 1'b0;
  assign dz = 1'b0;
  assign prod_nx = mul_nx;
`endif
  assign last = dz || cnt == LAST;
  assign DivZero = dz_q;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (Start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
  always_comb begin
    Busy = state != IDLE;
    Done = state == DONE;
    write_en_acc = state == DONE;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
      opnd <= '0;
      prod <= '0;
      op_q <= 1'b0;
      dz_q <= 1'b0;
      DataOut <= '0;
      HiOut <= '0;
    end else if (state == IDLE && Start) begin
      cnt <= '0;
      op_q <= op_in;
      opnd <= op_in ? RegIn : AccIn;
      prod <= {{W{1'b0}}, op_in ? AccIn : RegIn};
      dz_q <= 1'b0;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      prod <= prod_nx;
      if (last) begin
        DataOut <= dz ? '1 : prod_nx[W-1:0];
        HiOut <= dz ? prod[W-1:0] : prod_nx[2*W-1:W];
        dz_q <= dz;
      end
    end
  end
endmodule

// File: doc/acc_muldiv_unit.md
# acc_muldiv_unit

Iterative multi-cycle unsigned multiply/divide unit that sits directly upstream of the accumulator register. It takes the current accumulator value and a second operand from the register file, and computes over several cycles. On completion it drives the accumulator's data input together with a one-cycle write-enable pulse. The upper half of the product, or the remainder, is held on a side output for a later move instruction.

## Interface
- W, default 8: data path width; operands are W bits, full product is 2W bits.

- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request a new operation; sampled only in IDLE.
- Op  in  1  0 = multiply, 1 = divide.
- AccIn  in  W  operand A (multiplicand/dividend), from accumulator DataOut.
- RegIn  in  W  operand B (multiplier/divisor), from register file.
- Busy  out  1  high in RUN and DONE.
- Done  out  1  one-cycle completion pulse.
- write_en_acc  out  1  identical to Done; connects to accumulator write enable.
- DataOut  out  W  product low half / quotient; connects to accumulator DataIn.
- HiOut  out  W  product high half / remainder.
- DivZero  out  1  last completed divide had divisor 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Start=1 at an edge latches AccIn, RegIn and Op.
  - Clears the iteration counter and DivZero.
  - Moves to RUN.
- RUN: one iteration per edge.
  - Multiply: shift-add on a 2W-bit working product. If the current multiplier LSB is 1, add the multiplicand to the upper half, then shift right one bit.
  - Divide: restoring division with a W-bit partial remainder. Shift in the next dividend bit; if partial ≥ divisor, subtract and set the quotient bit.
  - After the W-th iteration, move to DONE.
- Divide with RegIn=0:
  - No iterations run; RUN moves to DONE on the first edge.
  - Quotient = all ones, remainder = dividend, DivZero=1.
- DONE: lasts exactly one cycle.
  - Done=write_en_acc=1.
  - DataOut/HiOut hold final results.
  - Next edge returns to IDLE.
- Results are registered; DataOut, HiOut and DivZero hold until the next completion or reset.
- Start while Busy=1 (RUN or DONE) is ignored, not queued.
- Start held high continuously: a new operation begins on the first edge in IDLE, i.e. back-to-back operations, one idle cycle apart.
- Operand inputs may change freely after the Start edge; only the latched copies are used.
- Arithmetic is unsigned; there is no overflow flag (the 2W-bit product always fits).

## Timing
- Reset (async, any state): state=IDLE, counter=0.
  - Busy=0, Done=0, write_en_acc=0, DataOut=0, HiOut=0, DivZero=0.
  - An operation in flight is discarded and no write pulse is issued.
- Normal latency: Start sampled at edge 0; iterations at edges 1..W; Done high from edge W to edge W+1.
- Done therefore asserts W cycles after the Start edge (8 cycles for W=8).
- Divide-by-zero latency: Done high from edge 1 to edge 2.
- Busy rises after edge 0 and falls after the edge ending DONE.
- DataOut and HiOut update at the edge entering DONE. They are valid for the whole Done cycle, so the accumulator captures DataOut at the edge ending DONE.
- Releasing Reset mid-cycle has no effect until the next rising edge.

## Configuration
- ACC_MULDIV_DIV_EN defined:
  - Divide datapath and DivZero logic are compiled in.
  - Op selects the operation as above.
- ACC_MULDIV_DIV_EN undefined:
  - The divider is removed and Op is ignored; every operation is a multiply with W-cycle latency.
  - DivZero is tied to 0.

## Test plan
- Multiply: AccIn=13, RegIn=11, Op=0 -> Done 8 cycles after the Start edge, DataOut=0x8F, HiOut=0x00, write_en_acc pulse of exactly 1 cycle.
- Maximum product: 255×255 -> DataOut=0x01, HiOut=0xFE.
- Divide (DIV_EN): 200/7 -> DataOut=0x1C, HiOut=0x04, DivZero=0, Done after 8 cycles.
- Divide by zero (DIV_EN): 0x5A/0 -> Done 1 cycle after Start, DataOut=0xFF, HiOut=0x5A, DivZero=1. DivZero then clears on the next Start.
- Start pulsed at cycles 3 and 5 of a running multiply -> ignored; exactly one Done, with the original operands' result.
- Reset asserted at iteration 4 -> outputs immediately 0 and Busy=0, no write_en_acc pulse. A new Start after release gives the correct result.
